// File: rtl/aha_clock_div_selector.sv
// -----------------------------------------------------------------------------
// aha_clock_div_selector
//
// Purpose:
//   Divide-by-2^k clock-enable generator built on one free-running counter.
//   Emits a one-cycle enable pulse per divided period plus a registered
//   divided-clock level. Ratio changes go through a REQ/ACK handshake and take
//   effect only on a period boundary shared by the old and the new ratio, so
//   no runt or stretched period is ever produced. Gating stops the outputs at
//   the next period boundary and restarts them on the same grid.
//
// Ports:
//   CLK          in   master clock, all logic on rising edge
//   RESETn       in   synchronous active-low reset
//   SELECT       in   requested ratio index (sampled with SELECT_REQ)
//   SELECT_REQ   in   one-cycle ratio change request
//   GATE_REQ     in   level, 1 = stop enables at next period boundary
//   SELECT_ACK   out  one-cycle pulse, requested ratio is now active
//   SELECT_ERR   out  one-cycle pulse, SELECT out of range, request dropped
//   BUSY         out  request accepted and waiting for a common boundary
//   ACTIVE_SEL   out  ratio index currently driving the outputs
//   GATED        out  outputs currently stopped
//   CLK_EN_OUT   out  enable pulse, one cycle per divided period
//   CLK_DIV_OUT  out  registered divided clock level (enable/status use only)
// -----------------------------------------------------------------------------
module aha_clock_div_selector #(
  parameter int NUM_DIV   = 6,
  parameter int SEL_W     = 3,
  parameter int RESET_SEL = 0
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [SEL_W-1:0] SELECT,
  input  logic             SELECT_REQ,
  input  logic             GATE_REQ,
  output logic             SELECT_ACK,
  output logic             SELECT_ERR,
  output logic             BUSY,
  output logic [SEL_W-1:0] ACTIVE_SEL,
  output logic             GATED,
  output logic             CLK_EN_OUT,
  output logic             CLK_DIV_OUT
);

  // The longest period (2^(NUM_DIV-1)) needs NUM_DIV-1 counter bits.
  localparam int CNT_W = (NUM_DIV - 1 > 1) ? (NUM_DIV - 1) : 1;
  // Per-ratio tables are sized to the full index range so every SEL_W-bit
  // index is legal; unused entries are tied off.
  localparam int NSEL  = 1 << SEL_W;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_active;
  logic [SEL_W-1:0]   r_pend;
  logic               r_gated;
  logic               r_en;
  logic               r_div;
  logic               r_ack;
  logic               r_err;

  state_t             w_state_next;
  logic [SEL_W-1:0]   w_active_next;
  logic [SEL_W-1:0]   w_pend_next;
  logic               w_gated_next;
  logic               w_en_next;
  logic               w_div_next;
  logic               w_ack_next;
  logic               w_err_next;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [NSEL-1:0]    w_bnd;      // w_bnd[k]: current cycle ends a 2^k period
  logic [NSEL-1:0]    w_div_bit;  // w_div_bit[k]: divided level after this edge
  logic [SEL_W-1:0]   w_max_sel;
  logic               w_sel_bad;
  logic               w_k_bnd;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NSEL; gi++) begin : g_ratio
      if (gi == 0) begin : g_k0
        assign w_bnd[gi]     = 1'b1;
        assign w_div_bit[gi] = 1'b1;
      end else if (gi < NUM_DIV) begin : g_kn
        assign w_bnd[gi]     = &r_cnt[gi-1:0];
        // High for the first half of each period, so it rises with the EN pulse.
        assign w_div_bit[gi] = ~w_cnt_inc[gi-1];
      end else begin : g_unused
        assign w_bnd[gi]     = 1'b0;
        assign w_div_bit[gi] = 1'b0;
      end
    end
  endgenerate

  // The boundary of the longer period is also a boundary of the shorter one.
  assign w_max_sel = (r_active > r_pend) ? r_active : r_pend;
  assign w_sel_bad = ({1'b0, SELECT} >= (SEL_W + 1)'(NUM_DIV));
  assign w_k_bnd   = w_bnd[r_active];

  always_comb begin
    w_state_next  = r_state;
    w_active_next = r_active;
    w_pend_next   = r_pend;
    w_gated_next  = r_gated;
    w_ack_next    = 1'b0;
    w_err_next    = 1'b0;

    // Outputs use the ratio and gate state in force during this cycle.
    w_en_next  = w_k_bnd & ~r_gated;
    w_div_next = ~r_gated & w_div_bit[r_active];

    if (w_k_bnd) begin
      w_gated_next = GATE_REQ;
    end

    case (r_state)
      S_IDLE: begin
        // Requests landing on the ACK cycle are dropped silently.
        if (SELECT_REQ && !r_ack) begin
          if (w_sel_bad) begin
            w_err_next = 1'b1;
          end else begin
            w_pend_next  = SELECT;
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_bnd[w_max_sel]) begin
          w_active_next = r_pend;
          w_ack_next    = 1'b1;
          w_state_next  = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_active <= SEL_W'(RESET_SEL);
      r_pend   <= '0;
      r_gated  <= 1'b0;
      r_en     <= 1'b0;
      r_div    <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_inc;
      r_active <= w_active_next;
      r_pend   <= w_pend_next;
      r_gated  <= w_gated_next;
      r_en     <= w_en_next;
      r_div    <= w_div_next;
      r_ack    <= w_ack_next;
      r_err    <= w_err_next;
    end
  end

  assign SELECT_ACK  = r_ack;
  assign SELECT_ERR  = r_err;
  assign BUSY        = (r_state == S_WAIT);
  assign ACTIVE_SEL  = r_active;
  assign GATED       = r_gated;
  assign CLK_EN_OUT  = r_en;
  assign CLK_DIV_OUT = r_div;

endmodule
